// File: rtl/rf_pkg.sv
// Shared types and helpers for the parametrised register file.
package rf_pkg;

  typedef enum logic {
    RF_IDLE  = 1'b0,
    RF_CLEAR = 1'b1
  } rf_state_t;

  // Select width for a given register count; at least one bit.
  function automatic int unsigned rf_aw(input int unsigned depth);
    int unsigned w;
    w = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < depth) w = i + 1;
    end
    return (w == 0) ? 1 : w;
  endfunction

endpackage

// File: rtl/rf_param_cell.sv
// One register-file entry: data word plus valid bit, clear has priority over write.
module rf_cell
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH      = 16,
  parameter bit          VALID_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             clr_en,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data  <= '0;
      valid <= VALID_INIT;
    end else if (clr_en) begin
      data  <= '0;
      valid <= 1'b1;
    end else if (wr_en) begin
      data  <= wr_data;
      valid <= 1'b1;
    end
  end

endmodule

// File: rtl/rf_param.sv
// Parametrised 2R1W register file with bypass, optional zero R0, valid tracking and scrub engine.
module rf_param
  import rf_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned DEPTH   = 8,
  parameter int unsigned AW      = rf_aw(DEPTH),
  parameter bit          BYPASS  = 1'b1,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    read1regsel,
  input  logic [AW-1:0]    read2regsel,
  input  logic             read1en,
  input  logic             read2en,
  input  logic [AW-1:0]    writeregsel,
  input  logic [WIDTH-1:0] writedata,
  input  logic             write,
  input  logic             clear,
  output logic [WIDTH-1:0] read1data,
  output logic [WIDTH-1:0] read2data,
  output logic             busy,
  output logic             wr_drop,
  output logic             err
);

  rf_state_t state, state_nx;
  logic [AW-1:0] idx, idx_nx;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] valid;
  logic             wr_ok;

  logic [1:0][AW-1:0]    rsel;
  logic [1:0][WIDTH-1:0] rdata;
  logic [1:0]            rvalid;

  assign busy  = (state == RF_CLEAR);
  assign wr_ok = write && !busy && !(ZERO_R0 && (writeregsel == '0));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= RF_IDLE;
      idx     <= '0;
      wr_drop <= 1'b0;
    end else begin
      state   <= state_nx;
      idx     <= idx_nx;
      wr_drop <= write && busy;
    end
  end

  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    case (state)
      RF_IDLE: begin
        if (clear) begin
          state_nx = RF_CLEAR;
          idx_nx   = '0;
        end
      end
      RF_CLEAR: begin
        idx_nx = idx + 1'b1;
        if (idx == AW'(DEPTH - 1)) begin
          state_nx = RF_IDLE;
          idx_nx   = '0;
        end
      end
      default: begin
        state_nx = RF_IDLE;
        idx_nx   = '0;
      end
    endcase
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_cell
    rf_cell #(
      .WIDTH     (WIDTH),
      .VALID_INIT(ZERO_R0 && (i == 0))
    ) u_cell (
      .clk    (clk),
      .rst    (rst),
      .wr_en  (wr_ok && (writeregsel == AW'(i))),
      .wr_data(writedata),
      .clr_en (busy && (idx == AW'(i))),
      .data   (regs[i]),
      .valid  (valid[i])
    );
  end

  assign rsel[0] = read1regsel;
  assign rsel[1] = read2regsel;

  // Bypassed write data counts as valid, so a read of the register being written never flags err.
  always_comb begin
    rdata  = '0;
    rvalid = '0;
    for (int unsigned p = 0; p < 2; p++) begin
      rdata[p]  = regs[rsel[p]];
      rvalid[p] = valid[rsel[p]];
      if (ZERO_R0 && (rsel[p] == '0)) begin
        rdata[p]  = '0;
        rvalid[p] = 1'b1;
      end else if (BYPASS && write && !busy && (writeregsel == rsel[p])) begin
        rdata[p]  = writedata;
        rvalid[p] = 1'b1;
      end
    end
  end

  assign read1data = rdata[0];
  assign read2data = rdata[1];
  assign err       = (read1en && !rvalid[0]) || (read2en && !rvalid[1]);

endmodule

// File: tb/tb_rf_param.sv
// Table-driven scoreboard bench for rf_param in three parameter configurations.
module tb_rf_param;

  typedef struct {
    string       name;
    int          dut;
    logic        rst;
    logic [2:0]  s1;
    logic        e1;
    logic [2:0]  s2;
    logic        e2;
    logic        w;
    logic [2:0]  ws;
    logic [15:0] wd;
    logic        c;
    logic [4:0]  care;   // {drop, busy, err, d2, d1}
    logic [15:0] x1;
    logic [15:0] x2;
    logic        xe;
    logic        xb;
    logic        xd;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [2:0]  r1s = '0, r2s = '0, ws = '0;
  logic        r1e = 1'b0, r2e = 1'b0, wr = 1'b0, clr = 1'b0;
  logic [15:0] wd = '0;

  logic [15:0] d1_a, d2_a, d1_b, d2_b, d1_z, d2_z;
  logic        busy_a, drop_a, err_a, busy_b, drop_b, err_b, busy_z, drop_z, err_z;

  int tests = 0;
  int fails = 0;
  vec_t exp_q[$];
  vec_t tbl[$];

  always #5 clk = ~clk;

  rf_param dut_a (
    .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s), .read1en(r1e), .read2en(r2e),
    .writeregsel(ws), .writedata(wd), .write(wr), .clear(clr),
    .read1data(d1_a), .read2data(d2_a), .busy(busy_a), .wr_drop(drop_a), .err(err_a)
  );

  rf_param #(.BYPASS(1'b0)) dut_b (
    .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s), .read1en(r1e), .read2en(r2e),
    .writeregsel(ws), .writedata(wd), .write(wr), .clear(clr),
    .read1data(d1_b), .read2data(d2_b), .busy(busy_b), .wr_drop(drop_b), .err(err_b)
  );

  rf_param #(.ZERO_R0(1'b1)) dut_z (
    .clk(clk), .rst(rst), .read1regsel(r1s), .read2regsel(r2s), .read1en(r1e), .read2en(r2e),
    .writeregsel(ws), .writedata(wd), .write(wr), .clear(clr),
    .read1data(d1_z), .read2data(d2_z), .busy(busy_z), .wr_drop(drop_z), .err(err_z)
  );

  function automatic vec_t mk(string n, int d, logic r, logic [2:0] s1, logic e1,
                              logic [2:0] s2, logic e2, logic w, logic [2:0] wsel,
                              logic [15:0] wdat, logic c, logic [4:0] care,
                              logic [15:0] x1, logic [15:0] x2, logic xe, logic xb, logic xd);
    vec_t v;
    v.name = n; v.dut = d; v.rst = r; v.s1 = s1; v.e1 = e1; v.s2 = s2; v.e2 = e2;
    v.w = w; v.ws = wsel; v.wd = wdat; v.c = c; v.care = care;
    v.x1 = x1; v.x2 = x2; v.xe = xe; v.xb = xb; v.xd = xd;
    return v;
  endfunction

  task automatic cmp(input string n, input string f, input logic [15:0] act, input logic [15:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s.%s actual=%h required=%h", n, f, act, req);
    end
  endtask

  task automatic check(input vec_t x);
    logic [15:0] a1, a2;
    logic ae, ab, ad;
    case (x.dut)
      0:       begin a1 = d1_a; a2 = d2_a; ae = err_a; ab = busy_a; ad = drop_a; end
      1:       begin a1 = d1_b; a2 = d2_b; ae = err_b; ab = busy_b; ad = drop_b; end
      default: begin a1 = d1_z; a2 = d2_z; ae = err_z; ab = busy_z; ad = drop_z; end
    endcase
    if (x.care[0]) cmp(x.name, "read1data", a1, x.x1);
    if (x.care[1]) cmp(x.name, "read2data", a2, x.x2);
    if (x.care[2]) cmp(x.name, "err", {15'd0, ae}, {15'd0, x.xe});
    if (x.care[3]) cmp(x.name, "busy", {15'd0, ab}, {15'd0, x.xb});
    if (x.care[4]) cmp(x.name, "wr_drop", {15'd0, ad}, {15'd0, x.xd});
  endtask

  // Inputs change 1 ns after the rising edge; outputs are checked on the falling edge.
  task automatic run(input vec_t v);
    vec_t x;
    @(posedge clk); #1;
    rst = v.rst; r1s = v.s1; r1e = v.e1; r2s = v.s2; r2e = v.e2;
    wr = v.w; ws = v.ws; wd = v.wd; clr = v.c;
    exp_q.push_back(v);
    @(negedge clk);
    x = exp_q.pop_front();
    check(x);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t v;
    int   cnt;

    tbl.push_back(mk("rst_r3",     0, 1, 3, 1, 0, 0, 0, 0, 16'h0,    0, 5'b11111, 16'h0,    16'h0,    1, 0, 0));
    tbl.push_back(mk("wr_r3_byp",  0, 1, 3, 1, 0, 0, 1, 3, 16'hBEEF, 0, 5'b11111, 16'hBEEF, 16'h0,    0, 0, 0));
    tbl.push_back(mk("rd_r3",      0, 1, 3, 1, 0, 0, 0, 0, 16'h0,    0, 5'b11111, 16'hBEEF, 16'h0,    0, 0, 0));
    tbl.push_back(mk("byp_r5",     0, 1, 3, 1, 5, 1, 1, 5, 16'h1234, 0, 5'b11111, 16'hBEEF, 16'h1234, 0, 0, 0));
    tbl.push_back(mk("nb_same",    1, 1, 3, 1, 6, 1, 1, 6, 16'h1234, 0, 5'b11111, 16'hBEEF, 16'h0,    1, 0, 0));
    tbl.push_back(mk("nb_next",    1, 1, 3, 1, 6, 1, 0, 0, 16'h0,    0, 5'b11111, 16'hBEEF, 16'h1234, 0, 0, 0));
    tbl.push_back(mk("z_wr_r0",    2, 1, 0, 1, 0, 0, 1, 0, 16'hFFFF, 0, 5'b11111, 16'h0,    16'h0,    0, 0, 0));
    tbl.push_back(mk("z_r0_after", 2, 1, 0, 1, 0, 0, 0, 0, 16'h0,    0, 5'b11111, 16'h0,    16'h0,    0, 0, 0));
    tbl.push_back(mk("r0_plain",   0, 1, 0, 1, 5, 1, 0, 0, 16'h0,    0, 5'b11111, 16'hFFFF, 16'h1234, 0, 0, 0));
    tbl.push_back(mk("err_r7",     0, 1, 3, 0, 7, 1, 0, 0, 16'h0,    0, 5'b11111, 16'hBEEF, 16'h0,    1, 0, 0));
    tbl.push_back(mk("err_masked", 0, 1, 3, 0, 7, 0, 0, 0, 16'h0,    0, 5'b11111, 16'hBEEF, 16'h0,    0, 0, 0));

    repeat (2) @(posedge clk);
    #1 rst = 1'b1;

    foreach (tbl[i]) run(tbl[i]);

    // Fill, then scrub with a dropped write, a mid-clear read and an ignored re-clear.
    for (int i = 0; i < 8; i++)
      run(mk("fill", 0, 1, 0, 0, 0, 0, 1, 3'(i), 16'hA5A5, 0, 5'b00000, 0, 0, 0, 0, 0));
    run(mk("clr_go", 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 1, 5'b11000, 0, 0, 0, 0, 0));
    for (int k = 0; k < 8; k++) begin
      v = mk($sformatf("clr_c%0d", k), 0, 1, 7, (k == 4), 0, 0, (k == 2), 2, 16'h5555, (k == 5),
             (k == 4) ? 5'b11101 : 5'b11000, 16'hA5A5, 16'h0, 0, 1, (k == 3));
      run(v);
    end
    run(mk("clr_done", 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 5'b11000, 0, 0, 0, 0, 0));
    for (int i = 0; i < 8; i++)
      run(mk($sformatf("post_clr%0d", i), 0, 1, 3'(i), 1, 3'(7 - i), 1, 0, 0, 16'h0, 0,
             5'b11111, 16'h0, 16'h0, 0, 0, 0));

    // Asynchronous reset part-way through a clear.
    run(mk("wr_r1", 0, 1, 0, 0, 0, 0, 1, 1, 16'h1111, 0, 5'b00000, 0, 0, 0, 0, 0));
    run(mk("clr2_go", 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 1, 5'b01000, 0, 0, 0, 0, 0));
    for (int k = 0; k < 3; k++)
      run(mk($sformatf("clr2_c%0d", k), 0, 1, 0, 0, 0, 0, 0, 0, 16'h0, 0, 5'b01000, 0, 0, 0, 1, 0));
    run(mk("rst_mid_clr", 0, 0, 1, 1, 7, 1, 0, 0, 16'h0, 0, 5'b11111, 16'h0, 16'h0, 1, 0, 0));
    run(mk("rst_release", 0, 1, 1, 1, 7, 1, 0, 0, 16'h0, 1, 5'b11111, 16'h0, 16'h0, 1, 0, 0));

    cnt = 0;
    for (int k = 0; k < 12; k++) begin
      @(posedge clk); #1;
      clr = 1'b0; wr = 1'b0; r1e = 1'b0; r2e = 1'b0;
      @(negedge clk);
      if (busy_a) cnt++;
    end
    cmp("reclr_len", "busy_cycles", 16'(cnt), 16'd8);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rf_param.md
Name: rf_param

Overview:
Parametrised successor to the 8x16 register file: configurable width and depth, two read ports and one write port.
- Adds write-to-read bypass, optional hardwired-zero R0 and per-register valid tracking. An err flag reports reads of never-written registers.
- Adds a sequential clear engine that scrubs the array one entry per cycle.
- Sits in the decode/writeback path of the uniprocessor datapath.

Parameters:
WIDTH, 16, data bits per register
DEPTH, 8, number of registers (power of 2, >=2)
AW, $clog2(DEPTH), select width (derived, not overridden)
BYPASS, 1, 1 = same-cycle write data forwarded to matching read port
ZERO_R0, 0, 1 = register 0 reads 0, ignores writes, always valid

Ports:
clk  in  1  clock, all state on rising edge
rst  in  1  asynchronous active-low reset
read1regsel  in  AW  read port 1 select
read2regsel  in  AW  read port 2 select
read1en  in  1  port 1 read is meaningful (qualifies err)
read2en  in  1  port 2 read is meaningful (qualifies err)
writeregsel  in  AW  write select
writedata  in  WIDTH  write data
write  in  1  write enable
clear  in  1  start sequential clear (single-cycle request)
read1data  out  WIDTH  port 1 data, combinational
read2data  out  WIDTH  port 2 data, combinational
busy  out  1  clear engine active
wr_drop  out  1  registered 1-cycle pulse: a write was dropped the previous cycle
err  out  1  combinational: an enabled read targets an invalid register

Behaviour:
- Reset (rst=0, async):
  - All regs = 0 and all valid = 0, except valid[0] = 1 when ZERO_R0.
  - state = IDLE, idx = 0, busy = 0, wr_drop = 0.
  - err = (read1en & !valid[read1regsel]) | (read2en & !valid[read2regsel]).
- Write (IDLE, write=1): at the clock edge, regs[writeregsel] <= writedata and valid[writeregsel] <= 1. Ignored for sel 0 when ZERO_R0, with no drop pulse.
- Read, combinational; per port:
  - If ZERO_R0 and sel=0, data = 0.
  - Else if BYPASS and write and !busy and writeregsel==sel, data = writedata and the register counts as valid for err.
  - Else data = regs[sel].
- err = OR over ports of (readNen & !effective_valid(readNsel)).
- FSM states:
  - IDLE: on clear=1, go to CLEAR next edge with idx = 0. A write in the same cycle is still performed; it is then zeroed by the clear.
  - CLEAR: busy = 1. Each edge: regs[idx] <= 0, valid[idx] <= 1, idx <= idx+1. When idx == DEPTH-1, go to IDLE and set idx = 0.
  - busy is high for exactly DEPTH cycles; the first write accepted is in the cycle after busy falls.
- During CLEAR:
  - write=1 is dropped and the array is unchanged; wr_drop = 1 on the next cycle.
  - clear=1 is ignored; there is no restart.
  - Reads return current contents, partially cleared; no bypass.
- idx wraps at the AW-bit boundary; DEPTH is a power of 2, so no out-of-range index.
- Reset mid-CLEAR aborts immediately to the reset state; valid bits are zeroed, not left partially set.
- Read and write of the same register in the same cycle with BYPASS=0: read returns the old value; the new value is visible next cycle.

Decomposition:
- rf_pkg:
  - typedef rf_state_t {RF_IDLE, RF_CLEAR}
  - function for the AW derivation
- One sub-module, rf_cell:
  - WIDTH data register plus valid bit, with async active-low reset.
  - Inputs: wr_en, wr_data, clr_en.
- The array is DEPTH instances of rf_cell; the top level holds the FSM, decode, bypass and err logic.

Test Plan:
1. Reset, then read1en=1 with read1regsel=3 -> read1data=0x0000, err=1. Write R3=0xBEEF, then read R3 next cycle -> 0xBEEF, err=0.
2. BYPASS=1: write R5=0x1234 while read2regsel=5 in the same cycle -> read2data=0x1234 that cycle, err=0. Repeat with BYPASS=0 -> read2data=0x0000 and err=1 when read2en=1.
3. ZERO_R0=1: write R0=0xFFFF -> read R0 = 0x0000 and err=0 with read1en=1; wr_drop stays 0.
4. Write all regs to 0xA5A5 and pulse clear -> busy high for 8 cycles. A read of R7 at cycle 4 returns 0xA5A5; after busy falls, every register reads 0x0000 and err=0.
5. write=1 to R2 with 0x5555 during CLEAR cycle 2 -> wr_drop=1 the next cycle; R2 reads 0x0000 after the clear.
6. Drive rst=0 asynchronously at CLEAR cycle 3 -> busy=0 immediately; all reads return 0 with err=1; a clear issued after release runs the full 8 cycles.
